// File: rtl/pulse_burst_gen.sv
// Programmable strobe burst generator: N single-cycle strobes separated by G idle cycles,
// followed by a one-cycle done pulse. Abortable; all outputs come straight from flops.
module pulse_burst_gen #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             abort,
    output logic             x_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    // State bits are {x_out, busy, done} so every output is a flop with no decode logic.
    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_PULSE = 3'b110;
    localparam logic [2:0] S_GAP   = 3'b010;
    localparam logic [2:0] S_DONE  = 3'b001;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gap_lat_q, gap_lat_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    // Next-state and datapath update for the burst sequencer.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        gap_lat_d = gap_lat_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (burst_len != CNT_ZERO) begin
                        state_d   = S_PULSE;
                        rem_d     = burst_len;
                        gap_lat_d = gap_len;
                    end else begin
                        state_d = S_DONE;
                        rem_d   = CNT_ZERO;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PULSE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    rem_d   = CNT_ZERO;
                end else if (rem_q == CNT_ONE) begin
                    state_d = S_DONE;
                    rem_d   = CNT_ZERO;
                end else begin
                    rem_d = rem_q - CNT_ONE;
                    if (gap_lat_q == GAP_ZERO) begin
                        state_d = S_PULSE;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = gap_lat_q;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    rem_d   = CNT_ZERO;
                end else if (gap_cnt_q == GAP_ONE) begin
                    state_d   = S_PULSE;
                    gap_cnt_d = GAP_ZERO;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                rem_d     = CNT_ZERO;
                gap_cnt_d = GAP_ZERO;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            rem_q     <= CNT_ZERO;
            gap_lat_q <= GAP_ZERO;
            gap_cnt_q <= GAP_ZERO;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            gap_lat_q <= gap_lat_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign x_out     = state_q[2];
    assign busy      = state_q[1];
    assign done      = state_q[0];
    assign remaining = rem_q;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Self-checking bench: directed scenarios plus random traffic compared cycle by cycle
// against a queue-based model that expands each accepted burst into its output timeline.
module tb_pulse_burst_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] burst_len;
    logic [3:0] gap_len;
    logic       abort;
    logic       x_out;
    logic       busy;
    logic       done;
    logic [7:0] remaining;

    pulse_burst_gen #(.CNT_W(8), .GAP_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .burst_len (burst_len),
        .gap_len   (gap_len),
        .abort     (abort),
        .x_out     (x_out),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    typedef struct packed {
        logic       x;
        logic       b;
        logic       d;
        logic [7:0] r;
    } cyc_t;

    localparam cyc_t IDLE_C = '{x: 1'b0, b: 1'b0, d: 1'b0, r: 8'd0};

    cyc_t cur;
    cyc_t exp_q[$];
    int   n_vec;
    int   n_err;
    int   pulse_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, expv);
        end
    endtask

    // Expand one burst into the per-cycle outputs the spec rules imply.
    task automatic push_burst(input logic [7:0] n, input logic [3:0] g);
        if (n == 8'd0) begin
            exp_q.push_back('{x: 1'b0, b: 1'b0, d: 1'b1, r: 8'd0});
        end else begin
            for (int k = 0; k < int'(n); k++) begin
                exp_q.push_back('{x: 1'b1, b: 1'b1, d: 1'b0, r: 8'(int'(n) - k)});
                if (k < int'(n) - 1) begin
                    for (int j = 0; j < int'(g); j++) begin
                        exp_q.push_back('{x: 1'b0, b: 1'b1, d: 1'b0, r: 8'(int'(n) - k - 1)});
                    end
                end
            end
            exp_q.push_back('{x: 1'b0, b: 1'b0, d: 1'b1, r: 8'd0});
        end
    endtask

    task automatic model_edge(input logic s, input logic [7:0] bl, input logic [3:0] gl, input logic ab);
        if (!cur.b && !cur.d && s) begin
            push_burst(bl, gl);
        end else if (cur.b && ab) begin
            exp_q.delete();
        end
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_C;
    endtask

    task automatic check_all();
        chk_val("x_out", 32'(x_out), 32'(cur.x));
        chk_val("busy", 32'(busy), 32'(cur.b));
        chk_val("done", 32'(done), 32'(cur.d));
        chk_val("remaining", 32'(remaining), 32'(cur.r));
        if (x_out === 1'b1) pulse_cnt++;
    endtask

    // Called at a negedge: drive inputs, let one rising edge happen, check at next negedge.
    task automatic step(input logic s, input logic [7:0] bl, input logic [3:0] gl, input logic ab);
        start     = s;
        burst_len = bl;
        gap_len   = gl;
        abort     = ab;
        @(posedge clk);
        model_edge(s, bl, gl, ab);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 4'($urandom), 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        pulse_cnt = 0;
        cur = IDLE_C;
        rst = 1'b0;
        start = 1'b0;
        burst_len = 8'd0;
        gap_len = 4'd0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check_all();
        rst = 1'b1;
        step(1'b0, 8'd0, 4'd0, 1'b1);

        // Basic burst 3 / gap 2.
        step(1'b1, 8'd3, 4'd2, 1'b0);
        idle_steps(9);

        // Back-to-back strobes feeding a mod-4 pulse counter.
        pulse_cnt = 0;
        step(1'b1, 8'd4, 4'd0, 1'b0);
        idle_steps(6);
        chk_val("mod4_counter", 32'(pulse_cnt % 4), 32'd0);
        chk_val("pulse_count4", 32'(pulse_cnt), 32'd4);

        // Zero-length request.
        step(1'b1, 8'd0, 4'd3, 1'b0);
        idle_steps(3);

        // Start while busy is ignored.
        pulse_cnt = 0;
        step(1'b1, 8'd5, 4'd1, 1'b0);
        idle_steps(2);
        step(1'b1, 8'd9, 4'd0, 1'b0);
        idle_steps(12);
        chk_val("pulse_count5", 32'(pulse_cnt), 32'd5);

        // Abort in the second gap of a burst of 4.
        step(1'b1, 8'd4, 4'd2, 1'b0);
        idle_steps(4);
        step(1'b0, 8'd0, 4'd0, 1'b1);
        idle_steps(6);

        // Maximum length burst.
        step(1'b1, 8'd255, 4'd0, 1'b0);
        idle_steps(260);

        // Asynchronous reset in the middle of a strobe.
        step(1'b1, 8'd3, 4'd0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk_val("rst_x_out", 32'(x_out), 32'd0);
        chk_val("rst_busy", 32'(busy), 32'd0);
        chk_val("rst_remaining", 32'(remaining), 32'd0);
        chk_val("rst_done", 32'(done), 32'd0);
        exp_q.delete();
        cur = IDLE_C;
        @(negedge clk);
        check_all();
        rst = 1'b1;
        step(1'b1, 8'd2, 4'd1, 1'b0);
        idle_steps(5);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) == 0,
                 (($urandom % 10) == 0) ? 8'($urandom) : 8'($urandom % 7),
                 4'($urandom % 4),
                 ($urandom % 25) == 0);
        end
        idle_steps(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_burst_gen.md
PULSE_BURST_GEN -- requirements
Module: pulse_burst_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the burst-length count.
REQ-002 SHALL have parameter GAP_W, default 4: width of the inter-pulse gap count.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin a burst; sampled each rising edge.
REQ-006 SHALL have port burst_len  input  CNT_W  number of strobes to issue; sampled only when start is accepted.
REQ-007 SHALL have port gap_len  input  GAP_W  idle cycles between strobes; sampled only when start is accepted.
REQ-008 SHALL have port abort  input  1  terminate the active burst.
REQ-009 SHALL have port x_out  output  1  single-cycle strobe stream, suitable for a pulse-counting FSM input.
REQ-010 SHALL have port busy  output  1  high while a burst is in progress.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port remaining  output  CNT_W  strobes still to be issued in the current burst.

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, PULSE, GAP, DONE; all outputs are functions of registered state only, glitch-free.
REQ-014 x_out SHALL be 1 exactly in cycles where state is PULSE; busy SHALL be 1 exactly in PULSE or GAP; done SHALL be 1 exactly in DONE.
REQ-015 IDLE: start=1 and burst_len!=0 -> accept; latch burst_len into remaining and gap_len into a gap register; next state PULSE (first strobe in the cycle after the accepting edge).
REQ-016 IDLE: start=1 and burst_len=0 -> next state DONE; no strobe is issued; remaining stays 0.
REQ-017 IDLE: start=0 -> stay IDLE; abort is ignored.
REQ-018 PULSE: remaining SHALL decrement by 1 on exit from each PULSE cycle.
REQ-019 PULSE: if remaining=1 -> DONE; else if latched gap=0 -> PULSE (back-to-back strobes, x_out held high); else -> GAP with the gap counter loaded to the latched gap.
REQ-020 GAP: the gap counter SHALL decrement each cycle; when it reaches 1 -> PULSE, so GAP lasts exactly gap_len cycles.
REQ-021 DONE: SHALL last exactly one cycle and then return to IDLE unconditionally; start in DONE is ignored.
REQ-022 start while busy=1 SHALL be ignored; burst_len and gap_len changes during a burst SHALL have no effect.
REQ-023 abort=1 in PULSE or GAP SHALL force next state IDLE, clear remaining to 0, and SHALL NOT produce done; if the current state is PULSE, that cycle's strobe still completes.
REQ-024 abort SHALL take priority over all PULSE/GAP transitions, including the final-strobe transition to DONE.
REQ-025 A burst of N strobes with gap G SHALL occupy exactly N+(N-1)*G cycles of busy, followed by one done cycle.
REQ-026 burst_len = 2^CNT_W-1 SHALL be supported without wrap; remaining SHALL never underflow below 0.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, x_out=0, busy=0, done=0, remaining=0, and clear the gap counter and latched registers, independent of clk.
REQ-028 Reset asserted mid-burst SHALL abandon the burst with no done pulse; after rst rises, the first start is accepted normally.

Verification
REQ-029 Reset, then start=1 with burst_len=3 and gap_len=2 for one cycle -> x_out pattern 1,0,0,1,0,0,1 starting the cycle after acceptance; remaining 3,2,2,2,1,1,1 then 0; done=1 for one cycle immediately after the last strobe; busy high for 7 cycles.
REQ-030 burst_len=4, gap_len=0 -> x_out high for 4 consecutive cycles, then done for one cycle; a downstream mod-4 pulse counter returns to its start state.
REQ-031 burst_len=0, start=1 -> done=1 in the next cycle, x_out and busy never assert.
REQ-032 During a burst of 5 with gap 1, pulse start with burst_len=9 -> ignored; exactly 5 strobes issued.
REQ-033 abort=1 during the second GAP of a burst of 4 -> IDLE next cycle, remaining=0, no done, no further strobes.
REQ-034 rst=0 asserted between clock edges mid-PULSE -> x_out, busy, and remaining go to 0 immediately; after rst rises, a new start with burst_len=2 and gap_len=1 yields x_out pattern 1,0,1 and then done.
